// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus an MMIO page holding a free-running
// cycle counter and a byte transmit FIFO drained over a valid/ready handshake.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [31:0]        r_ram  [RAM_WORDS];
  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW-1:0] r_wptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_ovf;
  logic [31:0]        r_cycle;

  logic              w_mmio;
  logic              w_sel_cyc;
  logic              w_sel_tx;
  logic              w_sel_stat;
  logic              w_ram_we;
  logic              w_cyc_wr;
  logic              w_stat_wr;
  logic              w_tx_wr;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [8:0]        w_cnt9;
  logic [31:0]       w_status;
  logic              w_unused_bits;

  // Byte lane bits never take part in decode; offsets are compared word-aligned.
  assign w_mmio     = (a[31:16] == 16'hFFFF);
  assign w_sel_cyc  = w_mmio && (a[15:2] == 14'h0000);
  assign w_sel_tx   = w_mmio && (a[15:2] == 14'h0001);
  assign w_sel_stat = w_mmio && (a[15:2] == 14'h0002);
  assign w_ram_idx  = a[RAM_AW+1:2];

  assign w_ram_we  = we && !w_mmio;
  assign w_cyc_wr  = we && w_sel_cyc;
  assign w_stat_wr = we && w_sel_stat;
  assign w_tx_wr   = we && w_sel_tx;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = tx_valid && tx_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign w_push  = w_tx_wr && (!w_full || w_pop);
  assign w_drop  = w_tx_wr && w_full && !w_pop;

  assign w_cnt9   = 9'(r_count);
  assign w_status = {16'h0000, w_cnt9[7:0], 5'b00000, r_ovf, w_full, w_empty};

  assign w_unused_bits = ^{a[1:0], w_cnt9[8]};

  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rptr];

  always_comb begin
    rd = 32'h0000_0000;
    if (!w_mmio) begin
      rd = r_ram[w_ram_idx];
    end else if (w_sel_cyc) begin
      rd = r_cycle;
    end else if (w_sel_stat) begin
      rd = w_status;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_ram_we) begin
      r_ram[w_ram_idx] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_fifo[r_wptr] <= wd[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_cycle <= 32'h0000_0000;
    end else begin
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      if (w_push) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr && wd[2]) begin
        r_ovf <= 1'b0;
      end
      if (w_cyc_wr) begin
        r_cycle <= wd;
      end else begin
        r_cycle <= r_cycle + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios followed by random traffic, all
// checked against a queue/array reference model of the memory stage.
module tb_dmem_mmio;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int n_vec = 0;
  int n_mis = 0;

  logic [31:0] m_ram [64];
  bit          m_ram_ok [64];
  logic [7:0]  m_q [$];
  bit          m_ovf;
  logic [31:0] m_cyc;
  bit          m_init = 1'b0;

  dmem_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mmio(input logic [31:0] addr);
    return addr[31:16] == 16'hFFFF;
  endfunction

  function automatic int ram_index(input logic [31:0] addr);
    return int'((addr >> 2) % 64);
  endfunction

  function automatic bit rd_known(input logic [31:0] addr);
    if (is_mmio(addr)) return m_init;
    return m_ram_ok[ram_index(addr)];
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] addr);
    logic [15:0] off;
    if (!is_mmio(addr)) return m_ram[ram_index(addr)];
    off = addr[15:0] & 16'hFFFC;
    if (off == 16'h0000) return m_cyc;
    if (off == 16'h0008)
      return {16'h0000, 8'(m_q.size()), 5'b00000, m_ovf, m_q.size() == 8, m_q.size() == 0};
    return 32'h0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit pop, req, acc, mm;
    logic [15:0] off;
    mm  = is_mmio(a);
    off = a[15:0] & 16'hFFFC;
    if (!reset) begin
      m_cyc = 32'h0;
      m_q.delete();
      m_ovf = 1'b0;
      m_init = 1'b1;
      return;
    end
    pop = (m_q.size() != 0) && tx_ready;
    req = we && mm && off == 16'h0004;
    acc = req && (m_q.size() < 8 || pop);
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(wd[7:0]);
    if (req && !acc) m_ovf = 1'b1;
    if (we && mm && off == 16'h0008 && wd[2]) m_ovf = 1'b0;
    if (we && mm && off == 16'h0000) m_cyc = wd;
    else m_cyc = m_cyc + 32'd1;
    if (we && !mm) begin
      m_ram[ram_index(a)] = wd;
      m_ram_ok[ram_index(a)] = 1'b1;
    end
  endtask

  task automatic step(input logic we_i, input logic [31:0] a_i, input logic [31:0] wd_i,
                      input logic txr_i);
    we = we_i; a = a_i; wd = wd_i; tx_ready = txr_i;
    @(negedge clk);
    if (m_init) begin
      if (rd_known(a)) check("rd", rd, exp_rd(a));
      check("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      check("tx_data", 32'(tx_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'h0);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic peek(input string tag, input logic [31:0] a_i, input logic [31:0] exp);
    we = 1'b0; a = a_i; wd = 32'h0;
    #1;
    check(tag, rd, exp);
  endtask

  localparam logic [31:0] CYC = 32'hFFFF_0000;
  localparam logic [31:0] TXD = 32'hFFFF_0004;
  localparam logic [31:0] STA = 32'hFFFF_0008;

  initial begin
    logic [31:0] ar;
    logic [15:0] offs [5] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0040};
    int busy;
    reset = 1'b0; we = 1'b0; a = 32'h0; wd = 32'h0; tx_ready = 1'b0;
    step(0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 32'h0, 0);
    peek("cyc_in_reset", CYC, 32'h0);
    peek("status_in_reset", STA, 32'h1);
    check("tx_valid_reset", 32'(tx_valid), 32'h0);
    check("tx_data_reset", 32'(tx_data), 32'h0);
    reset = 1'b1;

    // Counter counts from 0 after release, then wraps after a load.
    for (int i = 0; i < 5; i++) begin
      peek("cyc_count", CYC, 32'(i));
      step(0, CYC, 32'h0, 0);
    end
    step(1, CYC, 32'hFFFF_FFFE, 0);
    peek("cyc_load", CYC, 32'hFFFF_FFFE);
    step(0, CYC, 32'h0, 0);
    peek("cyc_max", CYC, 32'hFFFF_FFFF);
    step(0, CYC, 32'h0, 0);
    peek("cyc_wrap", CYC, 32'h0);

    // RAM write, byte-offset read and aliased read.
    step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0);
    peek("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
    peek("ram_rd_lowbits", 32'h0000_0013, 32'hDEAD_BEEF);
    peek("ram_rd_alias", 32'h0000_0110, 32'hDEAD_BEEF);
    step(0, 32'h0000_0010, 32'h0, 0);

    // FIFO ordering.
    for (int i = 0; i < 3; i++) step(1, TXD, 32'h41 + 32'(i), 0);
    peek("status_cnt3", STA, 32'h0000_0300);
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", 32'(tx_valid), 32'h1);
      check("drain_data", 32'(tx_data), 32'h41 + 32'(i));
      step(0, STA, 32'h0, 1);
    end
    check("drain_empty_valid", 32'(tx_valid), 32'h0);
    peek("status_empty", STA, 32'h1);

    // Fill past capacity, then clear overflow.
    for (int i = 0; i < 9; i++) step(1, TXD, 32'h60 + 32'(i), 0);
    peek("status_full_ovf", STA, 32'h0000_0806);
    step(1, STA, 32'h4, 0);
    peek("status_ovf_clr", STA, 32'h0000_0802);

    // Push while full with a simultaneous pop.
    step(1, TXD, 32'h55, 1);
    peek("status_full_pushpop", STA, 32'h0000_0802);
    for (int k = 0; k < 8; k++) begin
      check("full_drain_valid", 32'(tx_valid), 32'h1);
      check("full_drain_data", 32'(tx_data), (k < 7) ? 32'h61 + 32'(k) : 32'h55);
      step(0, STA, 32'h0, 1);
    end
    check("full_drain_empty", 32'(tx_valid), 32'h0);

    // Reset mid-stream.
    for (int i = 0; i < 3; i++) step(1, TXD, 32'h70 + 32'(i), 0);
    step(1, CYC, 32'd100, 0);
    peek("cyc_100", CYC, 32'd100);
    check("pre_reset_valid", 32'(tx_valid), 32'h1);
    reset = 1'b0;
    step(0, CYC, 32'h0, 0);
    check("post_reset_valid", 32'(tx_valid), 32'h0);
    peek("post_reset_status", STA, 32'h1);
    peek("post_reset_cyc", CYC, 32'h0);
    peek("post_reset_ram", 32'h0000_0010, 32'hDEAD_BEEF);
    reset = 1'b1;
    step(0, CYC, 32'h0, 0);
    peek("cyc_after_release", CYC, 32'h1);

    // Random traffic against the model.
    for (int it = 0; it < 800; it++) begin
      reset = ($urandom_range(0, 63) != 0);
      busy = (it < 400) ? 1 : 3;
      if ($urandom_range(0, 9) < 4) begin
        ar = $urandom;
        if (ar[31:16] == 16'hFFFF) ar[31] = 1'b0;
      end else begin
        ar = {16'hFFFF, offs[$urandom_range(0, 4)] | 16'($urandom_range(0, 3))};
      end
      step(logic'($urandom_range(0, 1)), ar, $urandom,
           logic'($urandom_range(0, 3) < busy));
    end
    reset = 1'b1;
    step(0, STA, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
